// File: rtl/bp_pkg.sv
// Shared helpers and defaults for the gshare direction predictor.
//  ctr_init  : reset value of a counter (weakly not-taken)
//  ctr_taken : taken threshold, i.e. the counter MSB
package bp_pkg;

  localparam int unsigned PC_BITS_DEF   = 16;
  localparam int unsigned IDX_BITS_DEF  = 8;
  localparam int unsigned HIST_BITS_DEF = 8;
  localparam int unsigned CTR_BITS_DEF  = 2;

  // 2**(ctr_bits-1)-1: the largest value that still predicts not-taken.
  function automatic logic [31:0] ctr_init(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

  // Predict taken when the counter MSB is set.
  function automatic logic ctr_taken(input logic [31:0] ctr, input int unsigned ctr_bits);
    logic [31:0] shifted;
    shifted = ctr >> (ctr_bits - 32'd1);
    return shifted[0];
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Combinational saturating increment/decrement of one predictor counter.
//  ctr    : current counter value
//  inc    : 1 = count up (taken), 0 = count down (not taken)
//  next_c : new value, clamped at all-ones and zero (no wrap-around)
module sat_counter_update #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] ctr,
  input  logic             inc,
  output logic [WIDTH-1:0] next_c
);

  always_comb begin
    next_c = ctr;
    if (inc) begin
      if (ctr != '1) next_c = ctr + WIDTH'(1);
    end else begin
      if (ctr != '0) next_c = ctr - WIDTH'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: speculative global history XOR PC indexes a table
// of saturating counters. Prediction is registered (one cycle after lookup);
// resolution trains the counter and a mispredict repairs the history.
//  clock, reset                  : rising-edge clock, async active-high reset
//  lookup_valid, lookup_pc       : branch being fetched
//  pred_valid/taken/idx/hist     : registered prediction plus tags carried with the branch
//  update_valid/idx/hist/taken   : resolving branch returning its tags and outcome
//  update_mispred                : repair history from update_hist (qualified by update_valid)
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_BITS   = PC_BITS_DEF,
  parameter int unsigned IDX_BITS  = IDX_BITS_DEF,
  parameter int unsigned HIST_BITS = HIST_BITS_DEF,
  parameter int unsigned CTR_BITS  = CTR_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [PC_BITS-1:0]   lookup_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_idx,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  input  logic                 update_mispred
);

  typedef logic [CTR_BITS-1:0]  ctr_t;
  typedef logic [IDX_BITS-1:0]  idx_t;
  typedef logic [HIST_BITS-1:0] hist_t;

  localparam int unsigned ENTRIES  = 32'd1 << IDX_BITS;
  localparam ctr_t        CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

  ctr_t  table_q [ENTRIES];
  hist_t bhr_q;
  hist_t bhr_next_c;
  hist_t bhr_spec_c;
  hist_t bhr_repair_c;
  idx_t  lookup_idx_c;
  logic  lookup_taken_c;
  ctr_t  upd_cur_c;
  ctr_t  upd_next_c;

  // PC[1:0] and PC bits above the index field never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^lookup_pc;

  // History is zero-extended into the index when it is narrower than the table.
  assign lookup_idx_c   = lookup_pc[IDX_BITS+1:2] ^ IDX_BITS'(bhr_q);
  assign lookup_taken_c = ctr_taken(32'(table_q[lookup_idx_c]), CTR_BITS);

  // Counter training on the update path.
  assign upd_cur_c = table_q[update_idx];

  sat_counter_update #(
    .WIDTH (CTR_BITS)
  ) u_sat (
    .ctr    (upd_cur_c),
    .inc    (update_taken),
    .next_c (upd_next_c)
  );

  // Shift-in values for speculation and repair; a 1-bit history has nothing to keep.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      logic unused_update_hist;
      assign unused_update_hist = ^update_hist;
      assign bhr_spec_c   = lookup_taken_c;
      assign bhr_repair_c = update_taken;
    end else begin : g_histn
      assign bhr_spec_c   = {bhr_q[HIST_BITS-2:0], lookup_taken_c};
      assign bhr_repair_c = {update_hist[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  // Mispredict repair overrides the speculative shift of a same-cycle lookup.
  always_comb begin
    bhr_next_c = bhr_q;
    if (lookup_valid) bhr_next_c = bhr_spec_c;
    if (update_valid && update_mispred) bhr_next_c = bhr_repair_c;
  end

  // Counter table: flops so every entry clears on async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= CTR_INIT;
    end else if (update_valid) begin
      table_q[update_idx] <= upd_next_c;
    end
  end

  // Global history register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bhr_q <= '0;
    else       bhr_q <= bhr_next_c;
  end

  // Registered prediction; tags hold while no lookup is presented.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
      pred_hist  <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken <= lookup_taken_c;
        pred_idx   <= lookup_idx_c;
        pred_hist  <= bhr_q;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized + directed bench for gshare_predictor against a behavioural model.
// DUT uses IDX_BITS=8, HIST_BITS=4, CTR_BITS=2 so the index sees zero-extended history.
module tb_gshare_predictor;

  localparam int PCW  = 16;
  localparam int IW   = 8;
  localparam int HW   = 4;
  localparam int CW   = 2;
  localparam int NENT = 256;
  localparam int HMOD = 16;
  localparam int CMAX = 3;
  localparam int CTHR = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           lookup_valid = 1'b0;
  logic [PCW-1:0] lookup_pc = '0;
  logic           pred_valid;
  logic           pred_taken;
  logic [IW-1:0]  pred_idx;
  logic [HW-1:0]  pred_hist;
  logic           update_valid = 1'b0;
  logic [IW-1:0]  update_idx = '0;
  logic [HW-1:0]  update_hist = '0;
  logic           update_taken = 1'b0;
  logic           update_mispred = 1'b0;

  gshare_predictor #(
    .PC_BITS   (PCW),
    .IDX_BITS  (IW),
    .HIST_BITS (HW),
    .CTR_BITS  (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .lookup_valid   (lookup_valid),
    .lookup_pc      (lookup_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .pred_hist      (pred_hist),
    .update_valid   (update_valid),
    .update_idx     (update_idx),
    .update_hist    (update_hist),
    .update_taken   (update_taken),
    .update_mispred (update_mispred)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: counters as integers, history as an integer modulo 2**HW.
  int m_ctr [NENT];
  int m_bhr;
  int m_pv, m_pt, m_pidx, m_phist;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
    m_bhr = 0; m_pv = 0; m_pt = 0; m_pidx = 0; m_phist = 0;
  endtask

  task automatic check_preds(input string tag);
    check_eq({tag, ".valid"}, 32'(pred_valid), 32'(m_pv));
    check_eq({tag, ".taken"}, 32'(pred_taken), 32'(m_pt));
    check_eq({tag, ".idx"},   32'(pred_idx),   32'(m_pidx));
    check_eq({tag, ".hist"},  32'(pred_hist),  32'(m_phist));
  endtask

  // One clock of stimulus; the model predicts from pre-edge state, then trains.
  task automatic step(input bit lv, input int pc, input bit uv, input int uidx,
                      input int uh, input bit ut, input bit um, input string tag);
    int nb;
    int i;
    lookup_valid   = lv;
    lookup_pc      = PCW'(pc);
    update_valid   = uv;
    update_idx     = IW'(uidx);
    update_hist    = HW'(uh);
    update_taken   = ut;
    update_mispred = um;
    nb = m_bhr;
    m_pv = lv ? 1 : 0;
    if (lv) begin
      i       = ((pc / 4) % NENT) ^ m_bhr;
      m_pt    = (m_ctr[i] >= CTHR) ? 1 : 0;
      m_pidx  = i;
      m_phist = m_bhr;
      nb      = (m_bhr * 2 + m_pt) % HMOD;
    end
    if (uv) begin
      if (ut) m_ctr[uidx] = (m_ctr[uidx] < CMAX) ? m_ctr[uidx] + 1 : CMAX;
      else    m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
      if (um) nb = (uh * 2 + (ut ? 1 : 0)) % HMOD;
    end
    m_bhr = nb;
    @(posedge clock);
    #1;
    check_preds(tag);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // Force history to h via a mispredict repair on a scratch entry (0xFF).
  task automatic set_bhr(input int h);
    step(0, 0, 1, 255, h / 2, h[0], 1, "set_bhr");
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_preds("reset");

    // 1: first lookup after reset
    step(1, 16'h0010, 0, 0, 0, 0, 0, "t1");
    check_eq("t1.idx_const", 32'(pred_idx), 32'h04);
    check_eq("t1.taken_const", 32'(pred_taken), 32'd0);

    // 2: saturate up then down on idx 0x04
    repeat (4) step(0, 0, 1, 4, 0, 1, 0, "t2.up");
    step(1, 16'h0010, 0, 0, 0, 0, 0, "t2.probe_hi");
    check_eq("t2.sat_hi", 32'(pred_taken), 32'd1);
    set_bhr(0);
    repeat (4) step(0, 0, 1, 4, 0, 0, 0, "t2.dn");
    step(0, 0, 1, 4, 0, 1, 0, "t2.to1");

    // 3: same-cycle lookup and update sees pre-update counter
    set_bhr(0);
    step(1, 16'h0010, 1, 4, 0, 1, 0, "t3.rbw");
    check_eq("t3.rbw_taken", 32'(pred_taken), 32'd0);
    set_bhr(0);
    step(1, 16'h0010, 0, 0, 0, 0, 0, "t3.after");
    check_eq("t3.after_taken", 32'(pred_taken), 32'd1);

    // 4: predictions 1,0,1 build history 0b101, then repair to 0
    set_bhr(0);
    step(1, 16'h0010, 0, 0, 0, 0, 0, "t4.a");
    step(1, 16'h0020, 0, 0, 0, 0, 0, "t4.b");
    step(1, 16'h0018, 0, 0, 0, 0, 0, "t4.c");
    check_eq("t4.pattern", 32'(pred_taken), 32'd1);
    step(1, 16'h0000, 0, 0, 0, 0, 0, "t4.probe");
    check_eq("t4.bhr101", 32'(pred_hist), 32'h5);
    step(0, 0, 1, 200, 0, 0, 1, "t4.repair");
    step(1, 16'h0000, 0, 0, 0, 0, 0, "t4.probe2");
    check_eq("t4.bhr0", 32'(pred_hist), 32'h0);

    // 5: repair beats the coincident lookup shift
    step(1, 16'h0040, 1, 201, 3, 1, 1, "t5.coinc");
    step(1, 16'h0000, 0, 0, 0, 0, 0, "t5.probe");
    check_eq("t5.bhr7", 32'(pred_hist), 32'h7);

    // 6: train idx 0x04 to 3, async reset mid-cycle clears at once
    repeat (3) step(0, 0, 1, 4, 0, 1, 0, "t6.train");
    step(1, 16'h0300, 0, 0, 0, 0, 0, "t6.pre");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_preds("t6.async");
    @(posedge clock);
    #1 reset = 1'b0;
    step(1, 16'h0010, 0, 0, 0, 0, 0, "t6.post");
    check_eq("t6.post_taken", 32'(pred_taken), 32'd0);
    check_eq("t6.post_hist", 32'(pred_hist), 32'd0);

    // Random traffic, including mispred without update_valid.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 16'hFFFF)),
           ($urandom_range(0, 1) == 1), int'($urandom_range(0, NENT - 1)),
           int'($urandom_range(0, HMOD - 1)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 3), "rand");
      if (n % 16 == 5) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
